// File: rtl/msm_pippenger_windowed.sv
// Windowed bucket-method (Pippenger) multi-scalar multiplier over curve_point_t,
// built around one shared multi-cycle point_add; curve package and adder included.
package elliptic_curve_structs;
  localparam int SCALAR_WIDTH = 256;
  localparam int FW = 16;
  localparam logic [FW-1:0] P_MOD  = 16'd65521;
  localparam logic [FW-1:0] A_COEF = 16'd2;

  typedef struct packed {
    logic          inf;
    logic [FW-1:0] x;
    logic [FW-1:0] y;
  } curve_point_t;

  localparam curve_point_t inf_point = '{inf: 1'b1, x: '0, y: '0};
endpackage

module point_add
  import elliptic_curve_structs::*;
(
  input  logic         clk,
  input  logic         arst,
  input  logic         Reset,
  input  curve_point_t P,
  input  curve_point_t Q,
  output curve_point_t R_add,
  output logic         add_done
);
  localparam logic [FW-1:0] INV_EXP = P_MOD - 16'd2;

  function automatic logic [FW-1:0] f_add(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic [FW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P_MOD}) s = s - {1'b0, P_MOD};
    return FW'(s);
  endfunction

  function automatic logic [FW-1:0] f_sub(input logic [FW-1:0] a, input logic [FW-1:0] b);
    return (a >= b) ? (a - b) : (a + (P_MOD - b));
  endfunction

  function automatic logic [FW-1:0] f_mul(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic [2*FW-1:0] m;
    m = {{FW{1'b0}}, a} * {{FW{1'b0}}, b};
    return FW'(m % {{FW{1'b0}}, P_MOD});
  endfunction

  // Fermat inversion a^(p-2), fully unrolled so the add resolves in one cycle
  function automatic logic [FW-1:0] f_inv(input logic [FW-1:0] a);
    logic [FW-1:0] r;
    r = FW'(1);
    for (int k = FW - 1; k >= 0; k--) begin
      r = f_mul(r, r);
      if (INV_EXP[k]) r = f_mul(r, a);
    end
    return r;
  endfunction

  curve_point_t  sum, r_q, r_d;
  logic          done_q, done_d;
  logic [FW-1:0] num, den, lam, x3, y3;

  always_comb begin
    sum = inf_point;
    num = '0;
    den = FW'(1);
    lam = '0;
    x3  = '0;
    y3  = '0;
    if (P.inf) begin
      sum = Q;
    end else if (Q.inf) begin
      sum = P;
    end else if (P.x == Q.x && (P.y != Q.y || P.y == '0)) begin
      sum = inf_point;
    end else begin
      if (P.x == Q.x) begin
        num = f_add(f_mul(FW'(3), f_mul(P.x, P.x)), A_COEF);
        den = f_add(P.y, P.y);
      end else begin
        num = f_sub(Q.y, P.y);
        den = f_sub(Q.x, P.x);
      end
      lam = f_mul(num, f_inv(den));
      x3  = f_sub(f_sub(f_mul(lam, lam), P.x), Q.x);
      y3  = f_sub(f_mul(lam, f_sub(P.x, x3)), P.y);
      sum.inf = 1'b0;
      sum.x   = x3;
      sum.y   = y3;
    end
  end

  always_comb begin
    r_d    = r_q;
    done_d = done_q;
    if (Reset) begin
      done_d = 1'b0;
    end else if (!done_q) begin
      r_d    = sum;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_q    <= inf_point;
      done_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      done_q <= done_d;
    end
  end

  assign R_add    = r_q;
  assign add_done = done_q;
endmodule

module msm_pippenger_windowed
  import elliptic_curve_structs::*;
#(
  parameter int LENGTH = 256,
  parameter int WINDOW = 4
) (
  input  logic                                clk,
  input  logic                                Reset,
  input  logic                                Start,
  input  curve_point_t [LENGTH-1:0]           G,
  input  logic [LENGTH-1:0][SCALAR_WIDTH-1:0] x,
  output logic                                Busy,
  output logic                                Done,
  output curve_point_t                        R,
  output logic [31:0]                         add_count
);
  localparam int NWIN = (SCALAR_WIDTH + WINDOW - 1) / WINDOW;
  localparam int NB   = (1 << WINDOW) - 1;
  localparam int XW   = NWIN * WINDOW;
  localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int IW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DBL, S_CLR, S_FILL, S_AGG_S, S_AGG_T, S_ACC, S_FIN
  } state_t;
  typedef enum logic {PH_ISSUE, PH_WAIT} phase_t;

  state_t             state_q, state_d;
  phase_t             ph_q, ph_d;
  logic [WW-1:0]      win_q, win_d;
  logic [IW-1:0]      i_q, i_d;
  logic [WINDOW-1:0]  b_q, b_d;
  logic [3:0]         k_q, k_d;
  curve_point_t       acc_q, acc_d, s_q, s_d, t_q, t_d, r_q, r_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [31:0]        cnt_q, cnt_d;
  curve_point_t       bkt_q [NB];
  curve_point_t       bkt_d [NB];

  logic [XW-1:0]      x_ext;
  logic [WINDOW-1:0]  digit, bidx;
  curve_point_t       bkt_rd, op_p, op_q, r_add;
  logic               add_done, add_issue, add_reset, fill_next;

  // Top window is zero-extended above SCALAR_WIDTH-1
  always_comb begin
    x_ext  = XW'(x[i_q]);
    digit  = x_ext[win_q*WINDOW +: WINDOW];
    bidx   = (state_q == S_FILL) ? (digit - 1'b1) : (b_q - 1'b1);
    bkt_rd = bkt_q[bidx];
  end

  always_comb begin
    op_p = acc_q;
    op_q = acc_q;
    case (state_q)
      S_FILL:  begin op_p = bkt_rd; op_q = G[i_q];  end
      S_AGG_S: begin op_p = s_q;    op_q = bkt_rd;  end
      S_AGG_T: begin op_p = t_q;    op_q = s_q;     end
      S_ACC:   begin op_p = acc_q;  op_q = t_q;     end
      default: ;
    endcase
  end

  assign add_reset = Reset | add_issue;

  point_add u_add (
    .clk      (clk),
    .arst     (Reset),
    .Reset    (add_reset),
    .P        (op_p),
    .Q        (op_q),
    .R_add    (r_add),
    .add_done (add_done)
  );

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    win_d     = win_q;
    i_d       = i_q;
    b_d       = b_q;
    k_d       = k_q;
    acc_d     = acc_q;
    s_d       = s_q;
    t_d       = t_q;
    r_d       = r_q;
    busy_d    = busy_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
    bkt_d     = bkt_q;
    add_issue = 1'b0;
    fill_next = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          win_d   = WW'(NWIN - 1);
          acc_d   = inf_point;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        for (int n = 0; n < NB; n++) bkt_d[n] = inf_point;
        i_d     = '0;
        ph_d    = PH_ISSUE;
        state_d = S_FILL;
      end
      S_FIN: begin
        r_d     = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        if (ph_q == PH_ISSUE) begin
          if (state_q == S_FILL && digit == '0) begin
            fill_next = 1'b1;
          end else begin
            add_issue = 1'b1;
            cnt_d     = cnt_q + 32'd1;
            ph_d      = PH_WAIT;
          end
        end else if (add_done) begin
          ph_d = PH_ISSUE;
          case (state_q)
            S_DBL: begin
              acc_d = r_add;
              if (k_q == '0) state_d = S_CLR;
              else k_d = k_q - 4'd1;
            end
            S_FILL: begin
              bkt_d[bidx] = r_add;
              fill_next   = 1'b1;
            end
            S_AGG_S: begin
              s_d     = r_add;
              state_d = S_AGG_T;
            end
            S_AGG_T: begin
              t_d = r_add;
              if (b_q == WINDOW'(1)) begin
                state_d = S_ACC;
              end else begin
                b_d     = b_q - 1'b1;
                state_d = S_AGG_S;
              end
            end
            S_ACC: begin
              acc_d = r_add;
              if (win_q == '0) begin
                state_d = S_FIN;
              end else begin
                win_d   = win_q - 1'b1;
                k_d     = 4'(WINDOW - 1);
                state_d = S_DBL;
              end
            end
            default: ;
          endcase
        end
        if (fill_next) begin
          if (i_q == IW'(LENGTH - 1)) begin
            s_d     = inf_point;
            t_d     = inf_point;
            b_d     = WINDOW'(NB);
            state_d = S_AGG_S;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ph_q    <= PH_ISSUE;
      win_q   <= '0;
      i_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      acc_q   <= inf_point;
      s_q     <= inf_point;
      t_q     <= inf_point;
      r_q     <= inf_point;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      for (int n = 0; n < NB; n++) bkt_q[n] <= inf_point;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      win_q   <= win_d;
      i_q     <= i_d;
      b_q     <= b_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      t_q     <= t_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      bkt_q   <= bkt_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign R         = r_q;
  assign add_count = cnt_q;
endmodule

// File: tb/tb_msm_pippenger_windowed.sv
// Directed bench for msm_pippenger_windowed: software affine-EC golden MSM,
// expectations queued at Start and compared when Done rises.
module tb_msm_pippenger_windowed;
  import elliptic_curve_structs::*;

  localparam int LEN = 4;
  localparam longint PM = 65521;
  localparam longint AC = 2;
  localparam curve_point_t GEN = '{inf: 1'b0, x: 16'd5, y: 16'd1234};

  typedef struct {
    curve_point_t r;
    int           cnt;
    string        tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     Reset, start4, start3;
  curve_point_t [LEN-1:0]   g4, g3;
  logic [LEN-1:0][255:0]    x4, x3;
  logic                     busy4, done4, busy3, done3;
  curve_point_t             r4, r3;
  logic [31:0]              cnt4, cnt3;

  exp_t         sbq[$];
  int           vectors = 0;
  int           miscompares = 0;
  curve_point_t last_r;

  msm_pippenger_windowed #(.LENGTH(LEN), .WINDOW(4)) dut4 (
    .clk(clk), .Reset(Reset), .Start(start4), .G(g4), .x(x4),
    .Busy(busy4), .Done(done4), .R(r4), .add_count(cnt4)
  );

  msm_pippenger_windowed #(.LENGTH(LEN), .WINDOW(3)) dut3 (
    .clk(clk), .Reset(Reset), .Start(start3), .G(g3), .x(x3),
    .Busy(busy3), .Done(done3), .R(r3), .add_count(cnt3)
  );

  function automatic longint md(input longint v);
    longint r;
    r = v % PM;
    if (r < 0) r += PM;
    return r;
  endfunction

  function automatic longint minv(input longint a);
    longint t, nt, r, nr, qq, tmp;
    t = 0; nt = 1; r = PM; nr = md(a);
    while (nr != 0) begin
      qq = r / nr;
      tmp = t - qq * nt; t = nt; nt = tmp;
      tmp = r - qq * nr; r = nr; nr = tmp;
    end
    return md(t);
  endfunction

  function automatic curve_point_t ec_add(input curve_point_t p, input curve_point_t q);
    longint x1, y1, x2, y2, l, xr, yr;
    curve_point_t o;
    if (p.inf) return q;
    if (q.inf) return p;
    x1 = longint'(p.x); y1 = longint'(p.y); x2 = longint'(q.x); y2 = longint'(q.y);
    if (x1 == x2) begin
      if (md(y1 + y2) == 0) return inf_point;
      l = md(md(3 * x1 * x1 + AC) * minv(2 * y1));
    end else begin
      l = md(md(y2 - y1) * minv(x2 - x1));
    end
    xr = md(l * l - x1 - x2);
    yr = md(l * (x1 - xr) - y1);
    o.inf = 1'b0;
    o.x = 16'(xr);
    o.y = 16'(yr);
    return o;
  endfunction

  function automatic curve_point_t ec_mul(input logic [255:0] k, input curve_point_t p);
    curve_point_t a;
    a = inf_point;
    for (int b = 255; b >= 0; b--) begin
      a = ec_add(a, a);
      if (k[b]) a = ec_add(a, p);
    end
    return a;
  endfunction

  function automatic curve_point_t golden(input curve_point_t [LEN-1:0] g,
                                          input logic [LEN-1:0][255:0] xs);
    curve_point_t s;
    s = inf_point;
    for (int i = 0; i < LEN; i++) s = ec_add(s, ec_mul(xs[i], g[i]));
    return s;
  endfunction

  function automatic int exp_adds(input logic [LEN-1:0][255:0] xs, input int w);
    int nwin, nb, nz;
    logic [263:0] t;
    nwin = (256 + w - 1) / w;
    nb = (1 << w) - 1;
    nz = 0;
    for (int i = 0; i < LEN; i++)
      for (int v = 0; v < nwin; v++) begin
        t = {8'b0, xs[i]} >> (v * w);
        if ((int'(t[7:0]) & nb) != 0) nz++;
      end
    return (nwin - 1) * w + nz + nwin * (2 * nb + 1);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic launch(input bit w3, input string tag, input int cnt_fixed);
    exp_t e;
    if (w3) begin
      e.r = golden(g3, x3);
      e.cnt = (cnt_fixed < 0) ? exp_adds(x3, 3) : cnt_fixed;
    end else begin
      e.r = golden(g4, x4);
      e.cnt = (cnt_fixed < 0) ? exp_adds(x4, 4) : cnt_fixed;
    end
    e.tag = tag;
    sbq.push_back(e);
    @(negedge clk);
    if (w3) start3 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    start4 = 1'b0;
    chk({tag, "_busy"}, w3 ? busy3 : busy4, 64'd1);
    chk({tag, "_done_low"}, w3 ? done3 : done4, 64'd0);
  endtask

  task automatic finish_run(input bit w3);
    exp_t e;
    int n;
    n = 0;
    while (!(w3 ? done3 : done4) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    e = sbq.pop_front();
    chk({e.tag, "_done"}, w3 ? done3 : done4, 64'd1);
    chk({e.tag, "_busy_low"}, w3 ? busy3 : busy4, 64'd0);
    chk({e.tag, "_R"}, w3 ? r3 : r4, 64'(e.r));
    chk({e.tag, "_adds"}, w3 ? cnt3 : cnt4, 64'(e.cnt));
    last_r = e.r;
  endtask

  initial begin
    Reset = 1'b1;
    start4 = 1'b0;
    start3 = 1'b0;
    g4 = '0; g3 = '0; x4 = '0; x3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy4, 64'd0);
    chk("rst_done", done4, 64'd0);
    chk("rst_R", r4, 64'(inf_point));
    chk("rst_adds", cnt4, 64'd0);
    chk("rst_busy_w3", busy3, 64'd0);
    Reset = 1'b0;

    for (int i = 0; i < LEN; i++) g4[i] = ec_mul(256'($urandom), GEN);
    x4 = '0;
    launch(1'b0, "zero", 2236);
    finish_run(1'b0);
    repeat (5) @(negedge clk);
    chk("zero_hold_done", done4, 64'd1);
    chk("zero_hold_R", r4, 64'(last_r));

    for (int i = 0; i < LEN; i++) g4[i] = GEN;
    x4[0] = 256'd1; x4[1] = 256'd2; x4[2] = 256'd3; x4[3] = 256'd4;
    launch(1'b0, "gen10", 2240);
    finish_run(1'b0);
    chk("gen10_is_10G", r4, 64'(ec_mul(256'd10, GEN)));

    for (int i = 0; i < LEN; i++) g4[i] = ec_mul(256'($urandom), GEN);
    x4[0] = '1;
    x4[1] = rand256();
    x4[2] = rand256() & {32{8'hF0}};
    x4[3] = rand256();
    launch(1'b0, "rand", -1);
    finish_run(1'b0);

    for (int i = 0; i < LEN; i++) g4[i] = ec_mul(256'($urandom), GEN);
    for (int i = 0; i < LEN; i++) x4[i] = rand256();
    launch(1'b0, "restart", -1);
    repeat (200) @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("restart_still_busy", busy4, 64'd1);
    repeat (3000) @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    finish_run(1'b0);

    x4[0] = rand256();
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (5) @(negedge clk);
    Reset = 1'b1;
    #1;
    chk("abort_busy", busy4, 64'd0);
    chk("abort_done", done4, 64'd0);
    chk("abort_R", r4, 64'(inf_point));
    chk("abort_adds", cnt4, 64'd0);
    @(negedge clk);
    Reset = 1'b0;
    launch(1'b0, "after_abort", -1);
    finish_run(1'b0);

    g3[0] = GEN;
    for (int i = 1; i < LEN; i++) g3[i] = ec_mul(256'($urandom), GEN);
    x3 = '0;
    x3[0][255] = 1'b1;
    launch(1'b1, "w3_top", 1546);
    finish_run(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
